// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, bus count, source indices and entry type for the writeback arbiter.
package wb_pkg;
    localparam int VREG_W     = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_WB_BUS = 3;

    localparam int SRC_ALU = 0;
    localparam int SRC_MUL = 1;
    localparam int SRC_LSU = 2;
    localparam int SRC_BRU = 3;

    typedef struct packed {
        logic [VREG_W-1:0] vregid;
        logic [DATA_W-1:0] val;
    } wb_entry_t;

    // (base + step) mod n for base < n and step <= n
    function automatic int rr_add(input int base, input int step, input int n);
        int s;
        s = base + step;
        return (s >= n) ? s - n : s;
    endfunction
endpackage

// File: rtl/writeback_arbiter_if.sv
// Result-source inputs and the three broadcast buses of the writeback arbiter.
interface writeback_arbiter_if #(
    parameter int NUM_SRC = 4
);
    import wb_pkg::*;

    logic                        flush;
    logic [NUM_SRC-1:0]          src_en;
    logic [NUM_SRC*VREG_W-1:0]   src_vregid;
    logic [NUM_SRC*DATA_W-1:0]   src_val;
    logic [NUM_SRC-1:0]          src_almost_full;

    logic                        writeback1_en;
    logic [VREG_W-1:0]           writeback1_vregid;
    logic [DATA_W-1:0]           writeback1_val;
    logic                        writeback2_en;
    logic [VREG_W-1:0]           writeback2_vregid;
    logic [DATA_W-1:0]           writeback2_val;
    logic                        writeback3_en;
    logic [VREG_W-1:0]           writeback3_vregid;
    logic [DATA_W-1:0]           writeback3_val;
    logic                        overflow;

    modport master (
        output flush, src_en, src_vregid, src_val,
        input  src_almost_full,
        input  writeback1_en, writeback1_vregid, writeback1_val,
        input  writeback2_en, writeback2_vregid, writeback2_val,
        input  writeback3_en, writeback3_vregid, writeback3_val,
        input  overflow
    );

    modport slave (
        input  flush, src_en, src_vregid, src_val,
        output src_almost_full,
        output writeback1_en, writeback1_vregid, writeback1_val,
        output writeback2_en, writeback2_vregid, writeback2_val,
        output writeback3_en, writeback3_vregid, writeback3_val,
        output overflow
    );
endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Single-source result FIFO; a push into a full FIFO is taken only when it is popped that cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        push_data,
    output wb_entry_t        pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // storage is never read before it is written, so it carries no reset
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Collects results from NUM_SRC producers into per-source FIFOs and broadcasts up to
// three per cycle on registered writeback buses, granted round-robin.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 4
) (
    input logic               clk,
    input logic               rst_n,
    writeback_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int GNT_W = $clog2(NUM_WB_BUS + 1);

    wb_entry_t             push_data [NUM_SRC];
    wb_entry_t             pop_data  [NUM_SRC];
    logic [CNT_W-1:0]      count     [NUM_SRC];
    logic [NUM_SRC-1:0]    full;
    logic [NUM_SRC-1:0]    empty;
    logic [NUM_SRC-1:0]    push;
    logic [NUM_SRC-1:0]    pop;
    logic [NUM_SRC-1:0]    drop;

    logic [SRC_W-1:0]      rr_ptr;
    logic [SRC_W-1:0]      cand;
    logic [SRC_W-1:0]      last_idx;
    logic [SRC_W-1:0]      next_ptr;
    logic [SRC_W-1:0]      bus_sel   [NUM_WB_BUS];
    logic [NUM_WB_BUS-1:0] bus_used;
    logic [GNT_W-1:0]      n_grant;

    logic [NUM_WB_BUS-1:0] wb_en_q;
    logic [VREG_W-1:0]     wb_vregid_q [NUM_WB_BUS];
    logic [DATA_W-1:0]     wb_val_q    [NUM_WB_BUS];
    logic                  overflow_q;

    assign push = bus.src_en & {NUM_SRC{~bus.flush}};
    assign drop = push & full & ~pop;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign push_data[i] = {bus.src_vregid[VREG_W*i +: VREG_W], bus.src_val[DATA_W*i +: DATA_W]};
        assign bus.src_almost_full[i] = (count[i] >= CNT_W'(DEPTH - 1));

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (bus.flush),
            .push      (push[i]),
            .pop       (pop[i]),
            .push_data (push_data[i]),
            .pop_data  (pop_data[i]),
            .count     (count[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

    // scan upward from rr_ptr, handing the first three non-empty sources to buses 1..3
    always_comb begin
        pop      = '0;
        bus_used = '0;
        n_grant  = '0;
        cand     = '0;
        last_idx = rr_ptr;
        for (int b = 0; b < NUM_WB_BUS; b++) bus_sel[b] = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = SRC_W'(rr_add(int'(rr_ptr), k, NUM_SRC));
            if (!empty[cand] && (n_grant < GNT_W'(NUM_WB_BUS))) begin
                pop[cand]         = 1'b1;
                bus_sel[n_grant]  = cand;
                bus_used[n_grant] = 1'b1;
                n_grant           = n_grant + GNT_W'(1);
                last_idx          = cand;
            end
        end
        next_ptr = SRC_W'(rr_add(int'(last_idx), 1, NUM_SRC));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q    <= '0;
            rr_ptr     <= '0;
            overflow_q <= 1'b0;
            for (int b = 0; b < NUM_WB_BUS; b++) begin
                wb_vregid_q[b] <= '0;
                wb_val_q[b]    <= '0;
            end
        end else begin
            if (|drop) overflow_q <= 1'b1;
            if (bus.flush) begin
                wb_en_q <= '0;
            end else begin
                wb_en_q <= bus_used;
                if (|bus_used) rr_ptr <= next_ptr;
                for (int b = 0; b < NUM_WB_BUS; b++) begin
                    if (bus_used[b]) begin
                        wb_vregid_q[b] <= pop_data[bus_sel[b]].vregid;
                        wb_val_q[b]    <= pop_data[bus_sel[b]].val;
                    end
                end
            end
        end
    end

    assign bus.writeback1_en     = wb_en_q[0];
    assign bus.writeback1_vregid = wb_vregid_q[0];
    assign bus.writeback1_val    = wb_val_q[0];
    assign bus.writeback2_en     = wb_en_q[1];
    assign bus.writeback2_vregid = wb_vregid_q[1];
    assign bus.writeback2_val    = wb_val_q[1];
    assign bus.writeback3_en     = wb_en_q[2];
    assign bus.writeback3_vregid = wb_vregid_q[2];
    assign bus.writeback3_val    = wb_val_q[2];
    assign bus.overflow          = overflow_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_writeback_arbiter;
    import wb_pkg::*;

    localparam int NS = 4;
    localparam int D  = 4;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    writeback_arbiter_if #(.NUM_SRC(NS)) ifc ();

    writeback_arbiter #(.NUM_SRC(NS), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    logic        act_en  [3];
    logic [4:0]  act_id  [3];
    logic [31:0] act_val [3];
    assign act_en[0]  = ifc.writeback1_en;
    assign act_id[0]  = ifc.writeback1_vregid;
    assign act_val[0] = ifc.writeback1_val;
    assign act_en[1]  = ifc.writeback2_en;
    assign act_id[1]  = ifc.writeback2_vregid;
    assign act_val[1] = ifc.writeback2_val;
    assign act_en[2]  = ifc.writeback3_en;
    assign act_id[2]  = ifc.writeback3_vregid;
    assign act_val[2] = ifc.writeback3_val;

    int checks   = 0;
    int failures = 0;

    // reference model: one queue of {vregid,val} per source
    logic [36:0] mq [NS][$];
    int          m_rr;
    logic        m_ovf;
    logic        exp_en  [3];
    logic [4:0]  exp_id  [3];
    logic [31:0] exp_val [3];

    function automatic logic [NS-1:0] model_af();
        logic [NS-1:0] r;
        for (int i = 0; i < NS; i++) r[i] = (mq[i].size() >= D - 1);
        return r;
    endfunction

    function automatic bit will_grant(input int s);
        int n;
        int c;
        n = 0;
        for (int k = 0; k < NS; k++) begin
            c = (m_rr + k) % NS;
            if (mq[c].size() > 0 && n < 3) begin
                if (c == s) return 1'b1;
                n++;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) mq[i].delete();
        m_rr  = 0;
        m_ovf = 1'b0;
        for (int b = 0; b < 3; b++) begin
            exp_en[b]  = 1'b0;
            exp_id[b]  = '0;
            exp_val[b] = '0;
        end
    endtask

    task automatic clr_in();
        ifc.flush      = 1'b0;
        ifc.src_en     = '0;
        ifc.src_vregid = '0;
        ifc.src_val    = '0;
    endtask

    task automatic set_src(input int i, input logic [4:0] id, input logic [31:0] v);
        ifc.src_en[i]           = 1'b1;
        ifc.src_vregid[5*i +: 5] = id;
        ifc.src_val[32*i +: 32]  = v;
    endtask

    task automatic top_up_others();
        for (int i = 0; i < NS; i++)
            if (i != 2 && mq[i].size() <= 1) set_src(i, 5'(i + 1), $urandom);
    endtask

    // advance the model by one edge using the inputs currently driven, then clock the DUT
    task automatic tick();
        int ng;
        int last;
        int s;
        logic [36:0] ent;
        for (int b = 0; b < 3; b++) exp_en[b] = 1'b0;
        if (ifc.flush) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
        end else begin
            ng   = 0;
            last = 0;
            for (int k = 0; k < NS; k++) begin
                s = (m_rr + k) % NS;
                if (ng < 3 && mq[s].size() > 0) begin
                    ent         = mq[s].pop_front();
                    exp_en[ng]  = 1'b1;
                    exp_id[ng]  = ent[36:32];
                    exp_val[ng] = ent[31:0];
                    last        = s;
                    ng++;
                end
            end
            if (ng > 0) m_rr = (last + 1) % NS;
            for (int i = 0; i < NS; i++) begin
                if (ifc.src_en[i]) begin
                    if (mq[i].size() < D) mq[i].push_back({ifc.src_vregid[5*i +: 5], ifc.src_val[32*i +: 32]});
                    else m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr_in();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (act_en[b] !== 1'b0 || act_id[b] !== 5'd0 || act_val[b] !== 32'd0) begin
                failures++;
                $display("FAIL reset_bus%0d: got en=%0b id=%0d val=%h, want 0/0/0", b + 1, act_en[b], act_id[b], act_val[b]);
            end
        end
        checks++;
        if (ifc.overflow !== 1'b0 || ifc.src_almost_full !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags: got ovf=%0b af=%b, want 0/0000", ifc.overflow, ifc.src_almost_full);
        end
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (act_en[0] !== 1'b0 || act_en[1] !== 1'b0 || act_en[2] !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got en=%0b%0b%0b, want 000", act_en[0], act_en[1], act_en[2]);
        end
    endtask

    task automatic test_all_sources();
        clr_in();
        for (int i = 0; i < NS; i++) set_src(i, 5'(10 + i), 32'hA000_0000 + i);
        tick();
        clr_in();
        checks++;
        if (act_en[0] !== 1'b0 || act_en[1] !== 1'b0 || act_en[2] !== 1'b0) begin
            failures++;
            $display("FAIL all_src_no_bypass: got en=%0b%0b%0b, want 000", act_en[0], act_en[1], act_en[2]);
        end
        tick();
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (act_en[b] !== 1'b1 || act_id[b] !== 5'(10 + b) || act_val[b] !== 32'hA000_0000 + b) begin
                failures++;
                $display("FAIL all_src_first_bus%0d: got en=%0b id=%0d val=%h, want 1/%0d/%h",
                         b + 1, act_en[b], act_id[b], act_val[b], 10 + b, 32'hA000_0000 + b);
            end
        end
        tick();
        checks++;
        if (act_en[0] !== 1'b1 || act_id[0] !== 5'd13 || act_val[0] !== 32'hA000_0003 ||
            act_en[1] !== 1'b0 || act_en[2] !== 1'b0) begin
            failures++;
            $display("FAIL all_src_second: got en=%0b%0b%0b id1=%0d val1=%h, want 100/13/a0000003",
                     act_en[0], act_en[1], act_en[2], act_id[0], act_val[0]);
        end
        checks++;
        if (act_id[1] !== 5'd11 || act_val[1] !== 32'hA000_0001 || act_id[2] !== 5'd12 || act_val[2] !== 32'hA000_0002) begin
            failures++;
            $display("FAIL all_src_hold: got id2=%0d val2=%h id3=%0d val3=%h, want 11/a0000001/12/a0000002",
                     act_id[1], act_val[1], act_id[2], act_val[2]);
        end
        // pointer must now be back at 0: source 0 ahead of source 3
        set_src(0, 5'd20, 32'h0000_0AAA);
        set_src(3, 5'd23, 32'h0000_0DDD);
        tick();
        clr_in();
        tick();
        checks++;
        if (act_en[0] !== 1'b1 || act_id[0] !== 5'd20 || act_en[1] !== 1'b1 || act_id[1] !== 5'd23 || act_en[2] !== 1'b0) begin
            failures++;
            $display("FAIL all_src_rr_wrap: got en=%0b%0b%0b id1=%0d id2=%0d, want 110/20/23",
                     act_en[0], act_en[1], act_en[2], act_id[0], act_id[1]);
        end
    endtask

    task automatic test_single_push();
        clr_in();
        set_src(1, 5'd5, 32'h0000_1234);
        tick();
        clr_in();
        checks++;
        if (act_en[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_no_bypass: got en1=%0b, want 0", act_en[0]);
        end
        tick();
        checks++;
        if (act_en[0] !== 1'b1 || act_id[0] !== 5'd5 || act_val[0] !== 32'h0000_1234 || act_en[1] !== 1'b0 || act_en[2] !== 1'b0) begin
            failures++;
            $display("FAIL single_broadcast: got en=%0b%0b%0b id=%0d val=%h, want 100/5/00001234",
                     act_en[0], act_en[1], act_en[2], act_id[0], act_val[0]);
        end
        tick();
        checks++;
        if (act_en[0] !== 1'b0 || act_id[0] !== 5'd5 || act_val[0] !== 32'h0000_1234) begin
            failures++;
            $display("FAIL single_idle_hold: got en=%0b id=%0d val=%h, want 0/5/00001234", act_en[0], act_id[0], act_val[0]);
        end
    endtask

    task automatic test_full_pop_push();
        bit          done;
        logic [31:0] last2;
        done  = 1'b0;
        last2 = '0;
        for (int c = 0; c < 64 && !done; c++) begin
            clr_in();
            top_up_others();
            if (mq[2].size() == D) begin
                if (will_grant(2)) begin
                    set_src(2, 5'd20, 32'h0000_BEEF);
                    done = 1'b1;
                end
            end else begin
                set_src(2, 5'd20, 32'($urandom_range(0, 32'h0000_BEEE)));
            end
            tick();
            for (int b = 0; b < 3; b++) begin
                checks++;
                if (act_en[b] !== exp_en[b] || act_id[b] !== exp_id[b] || act_val[b] !== exp_val[b]) begin
                    failures++;
                    $display("FAIL fill_bus%0d: got en=%0b id=%0d val=%h, want en=%0b id=%0d val=%h",
                             b + 1, act_en[b], act_id[b], act_val[b], exp_en[b], exp_id[b], exp_val[b]);
                end
            end
            checks++;
            if (ifc.src_almost_full !== model_af() || ifc.overflow !== m_ovf) begin
                failures++;
                $display("FAIL fill_flags: got af=%b ovf=%0b, want af=%b ovf=%0b", ifc.src_almost_full, ifc.overflow, model_af(), m_ovf);
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL full_pop_reach_full: got src2 count=%0d, want %0d with a same-cycle pop", mq[2].size(), D);
        end
        clr_in();
        for (int c = 0; c < 8; c++) begin
            tick();
            for (int b = 0; b < 3; b++) begin
                if (act_en[b] === 1'b1 && act_id[b] === 5'd20) last2 = act_val[b];
                checks++;
                if (act_en[b] !== exp_en[b] || act_id[b] !== exp_id[b] || act_val[b] !== exp_val[b]) begin
                    failures++;
                    $display("FAIL drain_bus%0d: got en=%0b id=%0d val=%h, want en=%0b id=%0d val=%h",
                             b + 1, act_en[b], act_id[b], act_val[b], exp_en[b], exp_id[b], exp_val[b]);
                end
            end
        end
        checks++;
        if (last2 !== 32'h0000_BEEF) begin
            failures++;
            $display("FAIL full_pop_last_value: got %h, want 0000beef", last2);
        end
        checks++;
        if (ifc.overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_pop_no_overflow: got %0b, want 0", ifc.overflow);
        end
    endtask

    task automatic test_flush();
        clr_in();
        for (int i = 0; i < 3; i++) set_src(i, 5'(24 + i), 32'hF100_0000 + i);
        tick();
        clr_in();
        ifc.flush = 1'b1;
        set_src(3, 5'd27, 32'hF100_0003);
        tick();
        clr_in();
        checks++;
        if (act_en[0] !== 1'b0 || act_en[1] !== 1'b0 || act_en[2] !== 1'b0) begin
            failures++;
            $display("FAIL flush_en_cleared: got en=%0b%0b%0b, want 000", act_en[0], act_en[1], act_en[2]);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (act_en[0] !== 1'b0 || act_en[1] !== 1'b0 || act_en[2] !== 1'b0 || ifc.overflow !== m_ovf) begin
                failures++;
                $display("FAIL flush_quiet: got en=%0b%0b%0b ovf=%0b, want 000 ovf=%0b",
                         act_en[0], act_en[1], act_en[2], ifc.overflow, m_ovf);
            end
        end
        set_src(1, 5'd9, 32'h0000_5A5A);
        tick();
        clr_in();
        tick();
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (act_en[b] !== exp_en[b] || act_id[b] !== exp_id[b] || act_val[b] !== exp_val[b]) begin
                failures++;
                $display("FAIL flush_after_bus%0d: got en=%0b id=%0d val=%h, want en=%0b id=%0d val=%h",
                         b + 1, act_en[b], act_id[b], act_val[b], exp_en[b], exp_id[b], exp_val[b]);
            end
        end
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 48 && !m_ovf; c++) begin
            clr_in();
            top_up_others();
            set_src(2, 5'd21, $urandom);
            tick();
            for (int b = 0; b < 3; b++) begin
                checks++;
                if (act_en[b] !== exp_en[b] || act_id[b] !== exp_id[b] || act_val[b] !== exp_val[b]) begin
                    failures++;
                    $display("FAIL ovf_bus%0d: got en=%0b id=%0d val=%h, want en=%0b id=%0d val=%h",
                             b + 1, act_en[b], act_id[b], act_val[b], exp_en[b], exp_id[b], exp_val[b]);
                end
            end
            checks++;
            if (ifc.src_almost_full !== model_af()) begin
                failures++;
                $display("FAIL ovf_almost_full: got %b, want %b (src2 count %0d)", ifc.src_almost_full, model_af(), mq[2].size());
            end
        end
        checks++;
        if (ifc.overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: got %0b, want 1", ifc.overflow);
        end
        clr_in();
        for (int c = 0; c < 8; c++) begin
            tick();
            for (int b = 0; b < 3; b++) begin
                checks++;
                if (act_en[b] !== exp_en[b] || act_id[b] !== exp_id[b] || act_val[b] !== exp_val[b]) begin
                    failures++;
                    $display("FAIL ovf_drain_bus%0d: got en=%0b id=%0d val=%h, want en=%0b id=%0d val=%h",
                             b + 1, act_en[b], act_id[b], act_val[b], exp_en[b], exp_id[b], exp_val[b]);
                end
            end
        end
        checks++;
        if (ifc.overflow !== 1'b1 || ifc.src_almost_full !== 4'b0) begin
            failures++;
            $display("FAIL overflow_sticky: got ovf=%0b af=%b, want 1/0000", ifc.overflow, ifc.src_almost_full);
        end
    endtask

    task automatic test_async_reset();
        for (int r = 0; r < 2; r++) begin
            clr_in();
            for (int i = 0; i < NS; i++) set_src(i, 5'($urandom), $urandom);
            tick();
        end
        clr_in();
        #3 rst_n = 1'b0;
        #1;
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (act_en[b] !== 1'b0 || act_id[b] !== 5'd0 || act_val[b] !== 32'd0) begin
                failures++;
                $display("FAIL async_reset_bus%0d: got en=%0b id=%0d val=%h, want 0/0/0", b + 1, act_en[b], act_id[b], act_val[b]);
            end
        end
        checks++;
        if (ifc.overflow !== 1'b0 || ifc.src_almost_full !== 4'b0) begin
            failures++;
            $display("FAIL async_reset_flags: got ovf=%0b af=%b, want 0/0000", ifc.overflow, ifc.src_almost_full);
        end
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (act_en[0] !== 1'b0 || act_en[1] !== 1'b0 || act_en[2] !== 1'b0) begin
                failures++;
                $display("FAIL async_reset_quiet: got en=%0b%0b%0b, want 000", act_en[0], act_en[1], act_en[2]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            clr_in();
            for (int i = 0; i < NS; i++)
                if ($urandom_range(0, 99) < 45) set_src(i, 5'($urandom), $urandom);
            if ($urandom_range(0, 31) == 0) ifc.flush = 1'b1;
            tick();
            for (int b = 0; b < 3; b++) begin
                checks++;
                if (act_en[b] !== exp_en[b] || act_id[b] !== exp_id[b] || act_val[b] !== exp_val[b]) begin
                    failures++;
                    $display("FAIL rand_bus%0d cycle %0d: got en=%0b id=%0d val=%h, want en=%0b id=%0d val=%h",
                             b + 1, c, act_en[b], act_id[b], act_val[b], exp_en[b], exp_id[b], exp_val[b]);
                end
            end
            checks++;
            if (ifc.src_almost_full !== model_af() || ifc.overflow !== m_ovf) begin
                failures++;
                $display("FAIL rand_flags cycle %0d: got af=%b ovf=%0b, want af=%b ovf=%0b",
                         c, ifc.src_almost_full, ifc.overflow, model_af(), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_sources();
        test_single_push();
        test_full_pop_push();
        test_flush();
        test_overflow();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
- REQ-001 Parameter NUM_SRC, default 4: number of producing units (ALU, MUL, LSU, BRU).
- REQ-002 Parameter DEPTH, default 4: entries per source FIFO (power of two).
- REQ-003 clk  input  1  single clock; all state on its rising edge.
- REQ-004 rst_n  input  1  reset, asynchronous, active-low.
- REQ-005 flush  input  1  synchronous clear of all buffered results (mispredict).
- REQ-006 src_en  input  NUM_SRC  per-source result valid.
- REQ-007 src_vregid  input  NUM_SRC*5  per-source destination virtual reg id, source i at bits [5i+4:5i].
- REQ-008 src_val  input  NUM_SRC*32  per-source result value, source i at bits [32i+31:32i].
- REQ-009 src_almost_full  output  NUM_SRC  per-source stall hint to the issuing reservation station.
- REQ-010 writeback1_en/writeback2_en/writeback3_en  output  1 each  broadcast bus valid.
- REQ-011 writeback1_vregid/writeback2_vregid/writeback3_vregid  output  5 each  broadcast tag.
- REQ-012 writeback1_val/writeback2_val/writeback3_val  output  32 each  broadcast value.
- REQ-013 overflow  output  1  sticky error: a result was dropped.

Function
- REQ-014 Each source SHALL own a DEPTH-entry FIFO holding {vregid, val}; src_en pushes on the rising edge.
- REQ-015 Each cycle, up to 3 non-empty FIFOs SHALL be granted, at most one pop per FIFO per cycle.
- REQ-016 Grant order SHALL be round-robin, starting at rr_ptr and scanning upward modulo NUM_SRC; first granted source drives bus 1, second bus 2, third bus 3.
- REQ-017 rr_ptr SHALL advance to (last granted index + 1) mod NUM_SRC when any grant occurs, else hold.
- REQ-018 Bus outputs SHALL be registered: an unused bus has en=0; vregid/val of an unused bus hold their previous value.
- REQ-019 Latency: a push on edge k into an empty FIFO whose source wins the grant SHALL appear on a bus after edge k+1; no same-cycle bypass.
- REQ-020 Push into a full FIFO SHALL be accepted when that FIFO is popped in the same cycle; otherwise it SHALL be dropped and overflow set to 1 until reset.
- REQ-021 Simultaneous push and pop on a non-full FIFO SHALL leave its count unchanged.
- REQ-022 src_almost_full[i] SHALL be combinational, 1 when count[i] >= DEPTH-1.
- REQ-023 FIFO pointers SHALL wrap modulo DEPTH; count width SHALL be log2(DEPTH)+1.
- REQ-024 flush SHALL empty all FIFOs, drive all writeback*_en to 0 on the next edge, and discard any src_en in the same cycle; rr_ptr and overflow are unaffected.
- REQ-025 Each source's results SHALL be broadcast in push order.

Reset
- REQ-026 rst_n low SHALL immediately clear all FIFO pointers/counts, writeback*_en, overflow and rr_ptr to 0, and drive src_almost_full to 0.
- REQ-027 writeback*_vregid/val SHALL reset to 0; FIFO storage need not be reset.
- REQ-028 Reset asserted mid-operation SHALL discard all buffered results; no broadcast follows reset release until a new push.

Structure
- REQ-029 Shared package wb_pkg SHALL hold VREG_W=5, DATA_W=32, NUM_WB_BUS=3 and the source index constants SRC_ALU=0, SRC_MUL=1, SRC_LSU=2, SRC_BRU=3.
- REQ-030 One sub-module wb_fifo (single-source FIFO with push/pop/count/full/empty) SHALL be instantiated NUM_SRC times; the grant logic stays in the top module.

Verification
- REQ-031 Single push src1 vregid=5 val=0x1234 at edge 0 -> writeback1_en=1, vregid=5, val=0x1234 after edge 1; buses 2/3 en=0.
- REQ-032 All 4 sources push together with rr_ptr=0 -> sources 0,1,2 on buses 1,2,3 in the next cycle, source 3 on bus 1 one cycle later, rr_ptr=3 then 0.
- REQ-033 Source 2 pushes 5 times back-to-back while sources 0,1,3 hold their FIFOs non-empty to delay source 2's pop -> src_almost_full[2]=1 at count 3, fifth push dropped, overflow=1 and sticky.
- REQ-034 FIFO full and popped same cycle while pushing val=0xBEEF -> no overflow, 0xBEEF broadcast last in order.
- REQ-035 flush with 3 entries buffered and a concurrent src_en -> all en=0 next cycle, no later broadcast of any of those values.
- REQ-036 rst_n asserted asynchronously mid-cycle with pending results -> outputs clear before next edge, nothing broadcast after release.
